// File: rtl/snake_pkg.sv
// Shared snake-game constants: one-hot direction codes, stepper FSM states
// and the reversal check used by the head stepper.
package snake_pkg;

    localparam logic [3:0] DIR_LEFT  = 4'b0001;
    localparam logic [3:0] DIR_RIGHT = 4'b0010;
    localparam logic [3:0] DIR_UP    = 4'b0100;
    localparam logic [3:0] DIR_DOWN  = 4'b1000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DEAD
    } state_t;

    function automatic logic is_opposite(input logic [3:0] a, input logic [3:0] b);
        return (a == DIR_LEFT  && b == DIR_RIGHT) ||
               (a == DIR_RIGHT && b == DIR_LEFT)  ||
               (a == DIR_UP    && b == DIR_DOWN)  ||
               (a == DIR_DOWN  && b == DIR_UP);
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Game tick divider: counts enabled cycles modulo STEP_DIV and flags the
// terminal-count cycle; clear holds the count at zero.
module snake_tick_gen #(
    parameter int unsigned STEP_DIV = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(STEP_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == TERM) ? '0 : count + CW'(1);
        end
    end

    always_comb begin
        tick = enable && !clear && (count == TERM);
    end

endmodule

// File: rtl/snake_head_stepper.sv
// Snake head stepper: advances the head one cell per game tick, filtering
// reversals/invalid codes. Define SNAKE_WRAP_EN to wrap at grid edges.
module snake_head_stepper
    import snake_pkg::*;
#(
    parameter  int unsigned GRID_W   = 40,
    parameter  int unsigned GRID_H   = 30,
    parameter  int unsigned STEP_DIV = 5_000_000,
    parameter  int unsigned START_X  = 20,
    parameter  int unsigned START_Y  = 15,
    localparam int unsigned X_W      = $clog2(GRID_W),
    localparam int unsigned Y_W      = $clog2(GRID_H)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic [3:0]     direction,
    output logic [X_W-1:0] head_x,
    output logic [Y_W-1:0] head_y,
    output logic [3:0]     heading,
    output logic           step,
    output logic           game_over
);

    localparam logic [X_W-1:0] X_MAX = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_H - 1);

    state_t         state, state_nx;
    logic           run;
    logic           tick;
    logic           edge_move;
    logic           collide;
    logic [3:0]     heading_nx;
    logic [X_W-1:0] x_nx;
    logic [Y_W-1:0] y_nx;

    snake_tick_gen #(
        .STEP_DIV (STEP_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!run),
        .enable (enable && run),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (enable) state_nx = RUN;
            RUN:     if (tick && collide) state_nx = DEAD;
            DEAD:    state_nx = DEAD;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        run = (state == RUN);
`ifdef SNAKE_WRAP_EN
        game_over = 1'b0;
`else
        game_over = (state == DEAD);
`endif
    end

    // Candidate heading and next cell; the wrapped cell is only committed
    // when edge moves are not collisions.
    always_comb begin
        heading_nx = heading;
        if ($onehot(direction) && !is_opposite(direction, heading)) begin
            heading_nx = direction;
        end
        x_nx      = head_x;
        y_nx      = head_y;
        edge_move = 1'b0;
        case (heading_nx)
            DIR_LEFT: begin
                if (head_x == '0) begin
                    edge_move = 1'b1;
                    x_nx      = X_MAX;
                end else begin
                    x_nx = head_x - X_W'(1);
                end
            end
            DIR_RIGHT: begin
                if (head_x == X_MAX) begin
                    edge_move = 1'b1;
                    x_nx      = '0;
                end else begin
                    x_nx = head_x + X_W'(1);
                end
            end
            DIR_UP: begin
                if (head_y == '0) begin
                    edge_move = 1'b1;
                    y_nx      = Y_MAX;
                end else begin
                    y_nx = head_y - Y_W'(1);
                end
            end
            DIR_DOWN: begin
                if (head_y == Y_MAX) begin
                    edge_move = 1'b1;
                    y_nx      = '0;
                end else begin
                    y_nx = head_y + Y_W'(1);
                end
            end
            default: ;
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign collide = 1'b0;
`else
    assign collide = edge_move;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_x  <= X_W'(START_X);
            head_y  <= Y_W'(START_Y);
            heading <= DIR_RIGHT;
            step    <= 1'b0;
        end else begin
            step <= 1'b0;
            if (tick) begin
                heading <= heading_nx;
                if (!collide) begin
                    head_x <= x_nx;
                    head_y <= y_nx;
                    step   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_snake_head_stepper.sv
// Self-checking bench for snake_head_stepper (STEP_DIV=4, 8x6 grid, start (4,3));
// honours SNAKE_WRAP_EN for the edge-move expectations.
module tb_snake_head_stepper;

    localparam int GRID_W   = 8;
    localparam int GRID_H   = 6;
    localparam int STEP_DIV = 4;
    localparam int START_X  = 4;
    localparam int START_Y  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] direction;
    logic [2:0] head_x;
    logic [2:0] head_y;
    logic [3:0] heading;
    logic       step;
    logic       game_over;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    // Reference model state: phase 0 idle, 1 running, 2 dead.
    int         m_phase, m_en, m_x, m_y, nx, ny;
    logic [3:0] m_head, opp;
    bit         m_step, m_go, off;

    snake_head_stepper #(
        .GRID_W   (GRID_W),
        .GRID_H   (GRID_H),
        .STEP_DIV (STEP_DIV),
        .START_X  (START_X),
        .START_Y  (START_Y)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .direction (direction),
        .head_x    (head_x),
        .head_y    (head_y),
        .heading   (heading),
        .step      (step),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_en    = 0;
            m_x     = START_X;
            m_y     = START_Y;
            m_head  = 4'b0010;
            m_step  = 1'b0;
            m_go    = 1'b0;
        end else begin
            m_step = 1'b0;
            if (m_phase == 0) begin
                if (enable) m_phase = 1;
            end else if (m_phase == 1 && enable) begin
                if (m_en % STEP_DIV == STEP_DIV - 1) begin
                    opp = {m_head[2], m_head[3], m_head[0], m_head[1]};
                    if ($countones(direction) == 1 && direction != opp) m_head = direction;
                    nx  = m_x + int'(m_head[1]) - int'(m_head[0]);
                    ny  = m_y + int'(m_head[3]) - int'(m_head[2]);
                    off = (nx < 0) || (nx >= GRID_W) || (ny < 0) || (ny >= GRID_H);
`ifdef SNAKE_WRAP_EN
                    m_x    = (nx + GRID_W) % GRID_W;
                    m_y    = (ny + GRID_H) % GRID_H;
                    m_step = 1'b1;
`else
                    if (off) begin
                        m_go    = 1'b1;
                        m_phase = 2;
                    end else begin
                        m_x    = nx;
                        m_y    = ny;
                        m_step = 1'b1;
                    end
`endif
                end
                m_en++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_head_x", int'(head_x), m_x);
            chk("model_head_y", int'(head_y), m_y);
            chk("model_heading", int'(heading), int'(m_head));
            chk("model_step", int'(step), int'(m_step));
            chk("model_game_over", int'(game_over), int'(m_go));
        end
    end

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        direction = 4'b0010;
        cyc(2);
        chk_on = 1'b1;
        chk("reset_x", int'(head_x), 4);
        chk("reset_y", int'(head_y), 3);
        chk("reset_heading", int'(heading), 2);
        chk("reset_step", int'(step), 0);
        chk("reset_game_over", int'(game_over), 0);

        rst_n  = 1'b1;
        enable = 1'b1;
        cyc(4);
        chk("no_step_before_edge5", int'(step), 0);
        chk("x_before_edge5", int'(head_x), 4);
        cyc(1);
        chk("first_step", int'(step), 1);
        chk("first_step_x", int'(head_x), 5);
        chk("first_step_y", int'(head_y), 3);

        direction = 4'b0001;
        cyc(4);
        chk("reverse_rejected_x", int'(head_x), 6);
        chk("reverse_rejected_heading", int'(heading), 2);
        chk("second_step", int'(step), 1);

        direction = 4'b0000;
        cyc(4);
        chk("zero_code_x", int'(head_x), 7);
        chk("zero_code_heading", int'(heading), 2);

        direction = 4'b0100;
        cyc(4);
        chk("turn_up_x", int'(head_x), 7);
        chk("turn_up_y", int'(head_y), 2);
        chk("turn_up_heading", int'(heading), 4);

        direction = 4'b0011;
        cyc(4);
        chk("multihot_y", int'(head_y), 1);
        chk("multihot_heading", int'(heading), 4);

        direction = 4'b0001;
        cyc(4);
        chk("turn_left_x", int'(head_x), 6);
        chk("turn_left_heading", int'(heading), 1);

        direction = 4'b0010;
        cyc(4);
        chk("reverse_left_x", int'(head_x), 5);

        direction = 4'b1000;
        cyc(4);
        chk("turn_down_y", int'(head_y), 2);

        direction = 4'b0010;
        cyc(4);
        chk("at_6_2_x", int'(head_x), 6);
        chk("at_6_2_y", int'(head_y), 2);

        cyc(2);
        rst_n = 1'b0;
        cyc(1);
        chk("midreset_x", int'(head_x), 4);
        chk("midreset_y", int'(head_y), 3);
        chk("midreset_heading", int'(heading), 2);
        chk("midreset_step", int'(step), 0);
        cyc(1);

        rst_n = 1'b1;
        cyc(4);
        chk("restart_no_step", int'(step), 0);
        cyc(1);
        chk("restart_step", int'(step), 1);
        chk("restart_x", int'(head_x), 5);

        cyc(2);
        enable = 1'b0;
        cyc(10);
        chk("pause_x", int'(head_x), 5);
        enable = 1'b1;
        cyc(1);
        chk("resume_no_step", int'(step), 0);
        cyc(1);
        chk("resume_step", int'(step), 1);
        chk("resume_x", int'(head_x), 6);

        cyc(4);
        chk("before_edge_x", int'(head_x), 7);
        cyc(4);
`ifdef SNAKE_WRAP_EN
        chk("wrap_x", int'(head_x), 0);
        chk("wrap_step", int'(step), 1);
        chk("wrap_game_over", int'(game_over), 0);
        cyc(12);
        chk("after_wrap_x", int'(head_x), 3);
`else
        chk("collide_x", int'(head_x), 7);
        chk("collide_step", int'(step), 0);
        chk("collide_game_over", int'(game_over), 1);
        cyc(12);
        chk("dead_x", int'(head_x), 7);
        chk("dead_game_over", int'(game_over), 1);
`endif

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
